// File: rtl/vco_afc_ctrl.sv
// VCO automatic frequency calibration: binary search of the 6-bit coarse
// frequency select against a feedback-pulse count measured over a fixed window.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; cfs holds the last result
// SETTLE  | cfs just changed, let the VCO settle, fb_pulse ignored
// MEASURE | count fb_pulse over the measurement window
// DECIDE  | resolve the current bit, advance to the next one or finish
// FINISH  | raise done and flag a result pinned at a code limit
module vco_afc_ctrl #(
    parameter int CNT_W      = 12,
    parameter int TARGET     = 1000,
    parameter int SETTLE_CYC = 64,
    parameter int WIN_CYC    = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fb_pulse,
    output logic [5:0] cfs,
    output logic       vhold,
    output logic       busy,
    output logic       done,
    output logic       range_err
);

    localparam int TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WIN_CYC - 1);
    localparam logic [CNT_W:0]   TGT       = (CNT_W + 1)'(TARGET);
    localparam logic [5:0]       CFS_MID   = 6'b100000;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        FINISH
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       cfs_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             done_nxt, range_err_nxt, busy_nxt;
    logic             over, under;

    // Comparisons carry one extra bit so TARGET may equal the counter ceiling.
    assign over  = {1'b0, count} > TGT;
    assign under = {1'b0, count} < TGT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfs       <= CFS_MID;
            bit_idx   <= 3'd5;
            timer     <= '0;
            count     <= '0;
            done      <= 1'b0;
            range_err <= 1'b0;
            busy      <= 1'b0;
            vhold     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfs       <= cfs_nxt;
            bit_idx   <= bit_idx_nxt;
            timer     <= timer_nxt;
            count     <= count_nxt;
            done      <= done_nxt;
            range_err <= range_err_nxt;
            busy      <= busy_nxt;
            vhold     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cfs_nxt       = cfs;
        bit_idx_nxt   = bit_idx;
        timer_nxt     = timer;
        count_nxt     = count;
        done_nxt      = done;
        range_err_nxt = range_err;

        case (state)
            IDLE: begin
                if (start) begin
                    cfs_nxt       = CFS_MID;
                    bit_idx_nxt   = 3'd5;
                    done_nxt      = 1'b0;
                    range_err_nxt = 1'b0;
                    timer_nxt     = SETTLE_LD;
                    state_nxt     = SETTLE;
                end
            end
            SETTLE: begin
                if (timer == '0) begin
                    timer_nxt = WIN_LD;
                    count_nxt = '0;
                    state_nxt = MEASURE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            MEASURE: begin
                if (fb_pulse && (count != '1)) begin
                    count_nxt = count + 1'b1;
                end
                if (timer == '0) begin
                    state_nxt = DECIDE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            DECIDE: begin
                if (over) begin
                    cfs_nxt[bit_idx] = 1'b0;
                end
                if (bit_idx != 3'd0) begin
                    cfs_nxt[bit_idx - 3'd1] = 1'b1;
                    bit_idx_nxt = bit_idx - 3'd1;
                    timer_nxt   = SETTLE_LD;
                    state_nxt   = SETTLE;
                end else begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done_nxt      = 1'b1;
                range_err_nxt = ((cfs == 6'd0) && over) || ((cfs == 6'd63) && under);
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // busy/vhold are registered from the next state so the VCO sees clean levels.
    always_comb begin
        busy_nxt = (state_nxt == SETTLE) || (state_nxt == MEASURE) || (state_nxt == DECIDE);
    end

endmodule

// File: tb/tb_vco_afc_ctrl.sv
// Directed bench for vco_afc_ctrl: three instances (search model, default timing,
// narrow saturating counter) exercised by per-scenario tasks.
module tb_vco_afc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_m = 1'b0, start_t = 1'b0, start_s = 1'b0;
    logic fb_m = 1'b0, fb_t = 1'b0, fb_s = 1'b1;

    logic [5:0] cfs_m, cfs_t, cfs_s;
    logic vhold_m, busy_m, done_m, rerr_m;
    logic vhold_t, busy_t, done_t, rerr_t;
    logic vhold_s, busy_s, done_s, rerr_s;

    int n_cmp = 0;
    int n_err = 0;

    // Main instance: window long enough to hold every model count.
    vco_afc_ctrl #(.CNT_W(12), .TARGET(1000), .SETTLE_CYC(8), .WIN_CYC(2000)) u_m (
        .clk(clk), .rst(rst), .start(start_m), .fb_pulse(fb_m),
        .cfs(cfs_m), .vhold(vhold_m), .busy(busy_m), .done(done_m), .range_err(rerr_m));

    vco_afc_ctrl u_t (
        .clk(clk), .rst(rst), .start(start_t), .fb_pulse(fb_t),
        .cfs(cfs_t), .vhold(vhold_t), .busy(busy_t), .done(done_t), .range_err(rerr_t));

    vco_afc_ctrl #(.CNT_W(8), .TARGET(200), .SETTLE_CYC(4), .WIN_CYC(300)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .fb_pulse(fb_s),
        .cfs(cfs_s), .vhold(vhold_s), .busy(busy_s), .done(done_s), .range_err(rerr_s));

    // VCO model: evenly spread pulses give exactly nval pulses in any 2000-cycle span.
    int mode = 0;
    int acc  = 0;
    int nval = 0;
    always begin
        @(posedge clk);
        #1;
        case (mode)
            0:       nval = 600 + 10 * int'(cfs_m);
            1:       nval = 2000;
            default: nval = 100;
        endcase
        acc = acc + nval;
        if (acc >= 2000) begin
            acc  = acc - 2000;
            fb_m = 1'b1;
        end else begin
            fb_m = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] trials[$];
    bit cal_to;

    task automatic run_m();
        trials.delete();
        cal_to  = 1'b1;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        for (int i = 0; i < 13000; i++) begin
            if (busy_m && (trials.size() == 0 || trials[$] != cfs_m)) trials.push_back(cfs_m);
            if (done_m) begin
                cal_to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (cfs_m !== 6'd32 || cfs_t !== 6'd32 || cfs_s !== 6'd32) begin
            n_err++; $display("FAIL reset_cfs: got %0d/%0d/%0d want 32", cfs_m, cfs_t, cfs_s);
        end
        n_cmp++;
        if ({busy_m, vhold_m, done_m, rerr_m, busy_t, vhold_t, done_t, rerr_t} !== 8'h00) begin
            n_err++; $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b want all 0",
                              busy_m, vhold_m, done_m, rerr_m, busy_t, vhold_t, done_t, rerr_t);
        end
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        n_cmp++;
        if (busy_m !== 1'b0) begin
            n_err++; $display("FAIL rst_priority: busy=%b want 0", busy_m);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy_m !== 1'b0) begin
            n_err++; $display("FAIL rst_no_start: busy=%b want 0", busy_m);
        end
    endtask

    task automatic test_timing();
        int c = 0;
        int rise = -1;
        logic busy_at = 1'bx;
        logic b1 = 1'bx, v1 = 1'bx;
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        while (c < 2500 && rise < 0) begin
            start_t = (c == 100 || c == 900);
            if (c == 1) begin b1 = busy_t; v1 = vhold_t; end
            tick();
            c++;
            if (done_t) begin
                rise = c;
                busy_at = busy_t;
            end
        end
        start_t = 1'b0;
        n_cmp++;
        if (b1 !== 1'b1 || v1 !== 1'b1) begin
            n_err++; $display("FAIL busy_vhold_running: got %b/%b want 1/1", b1, v1);
        end
        n_cmp++;
        if (rise !== 1927) begin
            n_err++; $display("FAIL done_latency: got %0d want 1927", rise);
        end
        n_cmp++;
        if (busy_at !== 1'b0 || vhold_t !== 1'b0) begin
            n_err++; $display("FAIL busy_at_done: busy=%b vhold=%b want 0/0", busy_at, vhold_t);
        end
        n_cmp++;
        if (cfs_t !== 6'd63 || rerr_t !== 1'b1) begin
            n_err++; $display("FAIL no_pulse_result: cfs=%0d rerr=%b want 63/1", cfs_t, rerr_t);
        end
        repeat (5) tick();
        n_cmp++;
        if (done_t !== 1'b1 || cfs_t !== 6'd63) begin
            n_err++; $display("FAIL done_hold: done=%b cfs=%0d want 1/63", done_t, cfs_t);
        end
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        n_cmp++;
        if (done_t !== 1'b0 || busy_t !== 1'b1 || cfs_t !== 6'd32) begin
            n_err++; $display("FAIL restart: done=%b busy=%b cfs=%0d want 0/1/32", done_t, busy_t, cfs_t);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] tr[$];
        logic [5:0] exp_tr[6] = '{6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1};
        bit to = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (busy_s && (tr.size() == 0 || tr[$] != cfs_s)) tr.push_back(cfs_s);
            if (done_s) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        n_cmp++;
        if (to) begin
            n_err++; $display("FAIL sat_timeout: done=%b want 1", done_s);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= tr.size() || tr[i] !== exp_tr[i]) begin
                n_err++; $display("FAIL sat_trial%0d: got %0d want %0d", i,
                                  (i < tr.size()) ? int'(tr[i]) : -1, exp_tr[i]);
            end
        end
        n_cmp++;
        if (cfs_s !== 6'd0 || rerr_s !== 1'b1) begin
            n_err++; $display("FAIL sat_result: cfs=%0d rerr=%b want 0/1", cfs_s, rerr_s);
        end
    endtask

    task automatic test_search(input int m, input logic [35:0] exp_pk,
                               input logic [5:0] exp_cfs, input logic exp_rerr);
        logic [5:0] exp_tr[6];
        for (int i = 0; i < 6; i++) exp_tr[i] = exp_pk[35 - 6*i -: 6];
        mode = m;
        run_m();
        n_cmp++;
        if (cal_to) begin
            n_err++; $display("FAIL search%0d_timeout: done=%b want 1", m, done_m);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= trials.size() || trials[i] !== exp_tr[i]) begin
                n_err++; $display("FAIL search%0d_trial%0d: got %0d want %0d", m, i,
                                  (i < trials.size()) ? int'(trials[i]) : -1, exp_tr[i]);
            end
        end
        n_cmp++;
        if (cfs_m !== exp_cfs || rerr_m !== exp_rerr || busy_m !== 1'b0 || vhold_m !== 1'b0) begin
            n_err++; $display("FAIL search%0d_result: cfs=%0d rerr=%b busy=%b vhold=%b want %0d/%b/0/0",
                              m, cfs_m, rerr_m, busy_m, vhold_m, exp_cfs, exp_rerr);
        end
    endtask

    task automatic test_rst_abort();
        bit saw_done = 1'b0;
        mode = 0;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        repeat (4500) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (cfs_m !== 6'd32 || busy_m !== 1'b0 || done_m !== 1'b0 || vhold_m !== 1'b0 || rerr_m !== 1'b0) begin
            n_err++; $display("FAIL abort_state: cfs=%0d busy=%b done=%b vhold=%b rerr=%b want 32/0/0/0/0",
                              cfs_m, busy_m, done_m, vhold_m, rerr_m);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done_m || busy_m) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_err++; $display("FAIL abort_quiet: done/busy seen=1 want 0");
        end
        run_m();
        n_cmp++;
        if (cal_to || cfs_m !== 6'd40 || rerr_m !== 1'b0 || trials.size() != 6) begin
            n_err++; $display("FAIL abort_rerun: cfs=%0d rerr=%b trials=%0d want 40/0/6",
                              cfs_m, rerr_m, trials.size());
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_saturation();
        test_search(0, {6'd32, 6'd48, 6'd40, 6'd44, 6'd42, 6'd41}, 6'd40, 1'b0);
        test_search(1, {6'd32, 6'd16, 6'd8,  6'd4,  6'd2,  6'd1 }, 6'd0,  1'b1);
        test_search(2, {6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd63}, 6'd63, 1'b1);
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
